// File: rtl/smi_axi_write_burst_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : smi_axi_write_burst_gen_pkg
// Description : Shared types, constants and burst-limit helper for the SMI
//               AXI write burst generator.
// Revision    : 1.0 - initial release
// ============================================================================
package smi_axi_write_burst_gen_pkg;

   // Frame-collection state: waiting for a setup, or gathering flits
   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } burst_state_t;

   // AXI bursts must never cross this address boundary
   localparam int unsigned c_PAGE_BYTES      = 4096;
   // Depth of the issued-burst length queue
   localparam int unsigned c_LEN_QUEUE_DEPTH = 4;

   // Beats available before the next 4 KiB page, capped by the burst length limit.
   // The offset is expected to already be flit-aligned.
   function automatic logic [8:0] burst_limit(input logic [11:0] offset,
                                              input int unsigned flit_width,
                                              input int unsigned max_len);
      int unsigned room;
      room = (c_PAGE_BYTES - 32'(offset)) / flit_width;
      if (room > max_len) room = max_len;
      return 9'(room);
   endfunction

endpackage
`default_nettype wire

// File: rtl/smi_axi_burst_len_queue.sv
`default_nettype none
// ============================================================================
// Module      : smi_axi_burst_len_queue
// Description : 4-entry synchronous FIFO holding AXI burst lengths (beats-1)
//               for bursts whose W beats have not yet completed.
// Revision    : 1.0 - initial release
// ============================================================================
module smi_axi_burst_len_queue (
   input  logic       clk,
   input  logic       srst,
   input  logic       push,
   input  logic [7:0] push_len,
   input  logic       pop,
   output logic [7:0] head_len,
   output logic       full,
   output logic       empty
);
   import smi_axi_write_burst_gen_pkg::*;

   logic [7:0] r_mem [c_LEN_QUEUE_DEPTH];
   logic [1:0] r_wr_ptr;
   logic [1:0] r_rd_ptr;
   logic [2:0] r_count;
   logic       w_push;
   logic       w_pop;

   assign full     = (r_count == 3'(c_LEN_QUEUE_DEPTH));
   assign empty    = (r_count == 3'd0);
   assign head_len = r_mem[r_rd_ptr];
   assign w_push   = push && !full;
   assign w_pop    = pop && !empty;

   // Storage array; contents are don't-care while the entry is not counted
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= push_len;
   end

   // Pointer and occupancy tracking; simultaneous push and pop keep the count
   always_ff @(posedge clk) begin
      if (srst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/smi_axi_write_burst_gen.sv
`default_nettype none
// ============================================================================
// Module      : smi_axi_write_burst_gen
// Description : Splits byte-aligned write flit frames into AXI4 write bursts
//               that respect a maximum length and never cross 4 KiB pages.
//               One AW command per burst; W beats released after their AW.
// Revision    : 1.0 - initial release
// ============================================================================
module smi_axi_write_burst_gen #(
   parameter int FLIT_WIDTH      = 16,
   parameter int MAX_BURST_LEN   = 16,
   parameter int FIFO_SIZE       = 32,
   parameter int FIFO_INDEX_SIZE = 5
) (
   input  logic                    clk,
   input  logic                    srst,
   input  logic                    setupReady,
   input  logic [63:0]             setupAddr,
   output logic                    setupStop,
   input  logic                    alignedInReady,
   input  logic [FLIT_WIDTH*8-1:0] alignedInData,
   input  logic [FLIT_WIDTH-1:0]   alignedInStrobes,
   input  logic                    alignedInLast,
   output logic                    alignedInStop,
   output logic                    axiAwValid,
   output logic [63:0]             axiAwAddr,
   output logic [7:0]              axiAwLen,
   input  logic                    axiAwReady,
   output logic                    axiWValid,
   output logic [FLIT_WIDTH*8-1:0] axiWData,
   output logic [FLIT_WIDTH-1:0]   axiWStrb,
   output logic                    axiWLast,
   input  logic                    axiWReady
);
   import smi_axi_write_burst_gen_pkg::*;

   localparam int c_LOG2_FW = $clog2(FLIT_WIDTH);
   localparam int c_ENTRY_W = FLIT_WIDTH * 9;

   burst_state_t                r_state, w_state_next;
   logic [63:0]                 r_addr;
   logic [8:0]                  r_limit, r_beat_count, w_beats;
   logic [63:0]                 w_setup_addr, w_next_addr;
   logic                        w_setup_xfer, w_in_xfer, w_close_cand, w_close, w_aw_busy;
   logic                        r_aw_valid, w_aw_hs;
   logic [63:0]                 r_aw_addr;
   logic [7:0]                  r_aw_len;
   logic [c_ENTRY_W-1:0]        r_fifo_mem [FIFO_SIZE];
   logic [FIFO_INDEX_SIZE-1:0]  r_wr_ptr, r_rd_ptr;
   logic [FIFO_INDEX_SIZE:0]    r_fifo_count;
   logic                        w_fifo_full, w_fifo_empty;
   logic                        r_w_valid, r_w_last, w_w_load, w_wlast_hs;
   logic [FLIT_WIDTH*8-1:0]     r_w_data;
   logic [FLIT_WIDTH-1:0]       r_w_strb;
   logic [7:0]                  r_beat_idx, w_q_head;
   logic [2:0]                  r_issued;
   logic                        w_q_full, w_q_empty;

   assign w_setup_addr = setupAddr & ~64'(FLIT_WIDTH - 1);
   assign w_beats      = r_beat_count + 9'd1;
   assign w_next_addr  = r_addr + (64'(w_beats) << c_LOG2_FW);
   assign w_setup_xfer = setupReady && !setupStop;
   assign w_in_xfer    = alignedInReady && !alignedInStop;
   assign w_close_cand = (w_beats == r_limit) || alignedInLast;
   assign w_close      = w_in_xfer && w_close_cand;
   // The AW slot frees up in the same cycle the held command is accepted
   assign w_aw_busy    = r_aw_valid && !axiAwReady;
   assign w_aw_hs      = r_aw_valid && axiAwReady;
   assign w_fifo_full  = (r_fifo_count == (FIFO_INDEX_SIZE + 1)'(FIFO_SIZE));
   assign w_fifo_empty = (r_fifo_count == '0);
   assign w_wlast_hs   = r_w_valid && r_w_last && axiWReady;
   // Load the W register only for an AW-accepted burst; the last beat of a
   // burst must handshake before the next burst's beats (and queue head) are used
   assign w_w_load     = (!r_w_valid || (axiWReady && !r_w_last)) &&
                         (r_issued != 3'd0) && !w_fifo_empty && !w_q_empty;

   // State register
   always_ff @(posedge clk) begin
      if (srst) r_state <= ST_IDLE;
      else      r_state <= w_state_next;
   end

   // Next-state: a setup opens a frame, the flit with last=1 closes it
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_setup_xfer) w_state_next = ST_COLLECT;
         ST_COLLECT: if (w_in_xfer && alignedInLast) w_state_next = ST_IDLE;
         default:    w_state_next = ST_IDLE;
      endcase
   end

   // Flow-control outputs: one frame at a time, flits stall on full FIFO or blocked close
   always_comb begin
      setupStop     = 1'b0;
      alignedInStop = 1'b1;
      case (r_state)
         ST_IDLE: begin
            setupStop     = 1'b0;
            alignedInStop = 1'b1;
         end
         ST_COLLECT: begin
            setupStop     = 1'b1;
            alignedInStop = w_fifo_full || (w_close_cand && (w_aw_busy || w_q_full));
         end
         default: ;
      endcase
   end

   // Burst address, limit and beat count for the burst being collected
   always_ff @(posedge clk) begin
      if (srst) begin
         r_addr       <= '0;
         r_limit      <= '0;
         r_beat_count <= '0;
      end else if (w_setup_xfer) begin
         r_addr       <= w_setup_addr;
         r_limit      <= burst_limit(w_setup_addr[11:0], FLIT_WIDTH, MAX_BURST_LEN);
         r_beat_count <= '0;
      end else if (w_close) begin
         r_addr       <= w_next_addr;
         r_limit      <= burst_limit(w_next_addr[11:0], FLIT_WIDTH, MAX_BURST_LEN);
         r_beat_count <= '0;
      end else if (w_in_xfer) begin
         r_beat_count <= w_beats;
      end
   end

   // AW command register, loaded on burst close and held until accepted
   always_ff @(posedge clk) begin
      if (srst) begin
         r_aw_valid <= 1'b0;
         r_aw_addr  <= '0;
         r_aw_len   <= '0;
      end else if (w_close) begin
         r_aw_valid <= 1'b1;
         r_aw_addr  <= r_addr;
         r_aw_len   <= r_beat_count[7:0];
      end else if (axiAwReady) begin
         r_aw_valid <= 1'b0;
      end
   end

   // W data FIFO storage; written on every accepted flit
   always_ff @(posedge clk) begin
      if (w_in_xfer) r_fifo_mem[r_wr_ptr] <= {alignedInData, alignedInStrobes};
   end

   // W data FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (srst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_fifo_count <= '0;
      end else begin
         if (w_in_xfer)
            r_wr_ptr <= (r_wr_ptr == FIFO_INDEX_SIZE'(FIFO_SIZE - 1)) ? '0 : r_wr_ptr + 1'b1;
         if (w_w_load)
            r_rd_ptr <= (r_rd_ptr == FIFO_INDEX_SIZE'(FIFO_SIZE - 1)) ? '0 : r_rd_ptr + 1'b1;
         case ({w_in_xfer, w_w_load})
            2'b10:   r_fifo_count <= r_fifo_count + 1'b1;
            2'b01:   r_fifo_count <= r_fifo_count - 1'b1;
            default: r_fifo_count <= r_fifo_count;
         endcase
      end
   end

   // Bursts whose AW was accepted but whose WLAST has not yet handshaked
   always_ff @(posedge clk) begin
      if (srst) begin
         r_issued <= '0;
      end else begin
         case ({w_aw_hs, w_wlast_hs})
            2'b10:   r_issued <= r_issued + 3'd1;
            2'b01:   r_issued <= r_issued - 3'd1;
            default: r_issued <= r_issued;
         endcase
      end
   end

   // W output register with beat index against the queued burst length
   always_ff @(posedge clk) begin
      if (srst) begin
         r_w_valid  <= 1'b0;
         r_w_last   <= 1'b0;
         r_w_data   <= '0;
         r_w_strb   <= '0;
         r_beat_idx <= '0;
      end else if (w_w_load) begin
         r_w_valid <= 1'b1;
         {r_w_data, r_w_strb} <= r_fifo_mem[r_rd_ptr];
         r_w_last  <= (r_beat_idx == w_q_head);
         if (r_beat_idx != w_q_head) r_beat_idx <= r_beat_idx + 8'd1;
      end else if (r_w_valid && axiWReady) begin
         r_w_valid <= 1'b0;
         r_w_last  <= 1'b0;
         if (r_w_last) r_beat_idx <= '0;
      end
   end

   smi_axi_burst_len_queue u_len_queue (
      .clk      (clk),
      .srst     (srst),
      .push     (w_close),
      .push_len (r_beat_count[7:0]),
      .pop      (w_wlast_hs),
      .head_len (w_q_head),
      .full     (w_q_full),
      .empty    (w_q_empty)
   );

   assign axiAwValid = r_aw_valid;
   assign axiAwAddr  = r_aw_addr;
   assign axiAwLen   = r_aw_len;
   assign axiWValid  = r_w_valid;
   assign axiWData   = r_w_data;
   assign axiWStrb   = r_w_strb;
   assign axiWLast   = r_w_last;

endmodule
`default_nettype wire

// File: tb/tb_smi_axi_write_burst_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_smi_axi_write_burst_gen
// Description : Scoreboard bench for smi_axi_write_burst_gen with directed
//               frames and hand-computed AW/W expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_smi_axi_write_burst_gen;

   logic         clk = 1'b0;
   logic         srst;
   logic         setupReady;
   logic [63:0]  setupAddr;
   logic         setupStop;
   logic         alignedInReady;
   logic [127:0] alignedInData;
   logic [15:0]  alignedInStrobes;
   logic         alignedInLast;
   logic         alignedInStop;
   logic         axiAwValid;
   logic [63:0]  axiAwAddr;
   logic [7:0]   axiAwLen;
   logic         axiAwReady;
   logic         axiWValid;
   logic [127:0] axiWData;
   logic [15:0]  axiWStrb;
   logic         axiWLast;
   logic         axiWReady;

   int checks = 0;
   int failures = 0;
   int frame_id = 0;
   int accepted = 0;
   int aw_hs = 0;
   int wl_hs = 0;
   int w_beats_seen = 0;
   bit w_first = 1'b1;
   bit aw_hold = 1'b0;
   bit rand_mode = 1'b0;

   logic [71:0]  exp_aw [$];
   logic [144:0] exp_w  [$];
   int           plan_q [$];

   smi_axi_write_burst_gen #(
      .FLIT_WIDTH(16), .MAX_BURST_LEN(16), .FIFO_SIZE(32), .FIFO_INDEX_SIZE(5)
   ) dut (
      .clk(clk), .srst(srst),
      .setupReady(setupReady), .setupAddr(setupAddr), .setupStop(setupStop),
      .alignedInReady(alignedInReady), .alignedInData(alignedInData),
      .alignedInStrobes(alignedInStrobes), .alignedInLast(alignedInLast),
      .alignedInStop(alignedInStop),
      .axiAwValid(axiAwValid), .axiAwAddr(axiAwAddr), .axiAwLen(axiAwLen),
      .axiAwReady(axiAwReady),
      .axiWValid(axiWValid), .axiWData(axiWData), .axiWStrb(axiWStrb),
      .axiWLast(axiWLast), .axiWReady(axiWReady)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Ready generator for the AXI side
   initial begin
      axiAwReady = 1'b0;
      axiWReady  = 1'b0;
      forever begin
         @(posedge clk); #1;
         axiAwReady = aw_hold ? 1'b0 : (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
         axiWReady  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // AW monitor: handshake happens at the coming posedge
   always @(negedge clk) begin
      if (!srst && axiAwValid && axiAwReady) begin
         if (exp_aw.size() == 0) check("aw_unexpected", {axiAwAddr, axiAwLen}, 72'h0);
         else check("aw_cmd", {axiAwAddr, axiAwLen}, exp_aw.pop_front());
         aw_hs++;
      end
   end

   // W monitor: data, strobes and WLAST per beat; first beat of a burst must follow its AW
   always @(negedge clk) begin
      if (!srst && axiWValid && axiWReady) begin
         if (w_first) check("w_after_aw", (aw_hs > wl_hs) ? 1 : 0, 1);
         if (exp_w.size() == 0) check("w_unexpected", {axiWLast, axiWStrb, axiWData}, 145'h0);
         else check("w_beat", {axiWLast, axiWStrb, axiWData}, exp_w.pop_front());
         w_beats_seen++;
         w_first = axiWLast;
         if (axiWLast) wl_hs++;
      end
   end

   task automatic expect_burst(input logic [63:0] addr, input int len);
      exp_aw.push_back({addr, 8'(len)});
      plan_q.push_back(len);
   endtask

   task automatic wait_accept(input bit is_setup, output bit ok);
      int cyc;
      bit acc;
      ok  = 1'b0;
      cyc = 0;
      while (!ok && cyc < 2000) begin
         @(negedge clk);
         acc = is_setup ? !setupStop : !alignedInStop;
         @(posedge clk); #1;
         cyc++;
         ok = acc;
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL %s actual=timeout required=accept", is_setup ? "setup_wait" : "flit_wait");
      end
   endtask

   // Issue one frame of n flits (only n_send of them are driven)
   task automatic run_frame(input logic [63:0] addr, input int n, input int n_send,
                            input logic [15:0] strb_fix, input bit expect_it);
      int rem;
      bit ok;
      logic [127:0] d;
      logic [15:0]  s;
      rem = 0;
      frame_id++;
      setupReady = 1'b1;
      setupAddr  = addr;
      wait_accept(1'b1, ok);
      setupReady = 1'b0;
      setupAddr  = '0;
      if (!ok) return;
      for (int i = 0; i < n_send; i++) begin
         d = {addr[31:0], 32'(frame_id), 32'(i), 32'hC0DE_0000 ^ 32'(i)};
         s = (strb_fix != 16'h0) ? strb_fix : ((i % 3 == 0) ? 16'h0FF0 : 16'hFFFF);
         if (expect_it) begin
            if (rem == 0 && plan_q.size() != 0) rem = plan_q.pop_front() + 1;
            rem--;
            exp_w.push_back({(rem == 0), s, d});
         end
         alignedInReady   = 1'b1;
         alignedInData    = d;
         alignedInStrobes = s;
         alignedInLast    = (i == n - 1);
         wait_accept(1'b0, ok);
         if (!ok) break;
         accepted++;
         if (i == 0 && n > 1) check("setup_blocked", setupStop, 1);
      end
      alignedInReady = 1'b0;
      alignedInLast  = 1'b0;
   endtask

   task automatic drain();
      int c;
      c = 0;
      while ((exp_aw.size() != 0 || exp_w.size() != 0) && c < 3000) begin
         @(posedge clk);
         c++;
      end
      check("drain_aw", exp_aw.size(), 0);
      check("drain_w", exp_w.size(), 0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      srst = 1'b1;
      setupReady = 1'b0; setupAddr = '0;
      alignedInReady = 1'b0; alignedInData = '0; alignedInStrobes = '0; alignedInLast = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_awvalid", axiAwValid, 0);
      check("rst_wvalid", axiWValid, 0);
      check("rst_wlast", axiWLast, 0);
      check("rst_setupstop", setupStop, 0);
      srst = 1'b0;
      @(posedge clk); #1;

      // 40 flits from 0x1000: two full bursts then 8 beats
      expect_burst(64'h1000, 15); expect_burst(64'h1100, 15); expect_burst(64'h1200, 7);
      run_frame(64'h1000, 40, 40, 16'h0, 1'b1);
      drain();

      // 4 KiB crossing: 4 beats up to 0x2000, then 6
      expect_burst(64'h1FC0, 3); expect_burst(64'h2000, 5);
      run_frame(64'h1FC0, 10, 10, 16'h0, 1'b1);
      drain();

      // Single-flit frame with partial strobes
      expect_burst(64'h0, 0);
      run_frame(64'h0, 1, 1, 16'h00FF, 1'b1);
      drain();

      // AW held off: 16 beats close into the AW slot, 15 more collect, 32nd close stalls
      accepted = 0;
      w_beats_seen = 0;
      aw_hold = 1'b1;
      expect_burst(64'h000, 15); expect_burst(64'h100, 15);
      expect_burst(64'h200, 15); expect_burst(64'h300, 15);
      fork
         run_frame(64'h0, 64, 64, 16'h0, 1'b1);
         begin
            repeat (100) @(posedge clk);
            #2;
            check("stall_accepted", accepted, 31);
            check("stall_instop", alignedInStop, 1);
            check("stall_no_w", w_beats_seen, 0);
            aw_hold = 1'b0;
         end
      join
      drain();

      // Three back-to-back frames with random AXI readiness (includes 64-bit wrap)
      rand_mode = 1'b1;
      expect_burst(64'h3F80, 7); expect_burst(64'h4000, 11);
      run_frame(64'h3F80, 20, 20, 16'h0, 1'b1);
      expect_burst(64'h5000, 15); expect_burst(64'h5100, 0);
      run_frame(64'h5008, 17, 17, 16'h0, 1'b1);
      expect_burst(64'hFFFF_FFFF_FFFF_FFE0, 1); expect_burst(64'h0, 2);
      run_frame(64'hFFFF_FFFF_FFFF_FFE0, 5, 5, 16'h0, 1'b1);
      drain();
      rand_mode = 1'b0;

      // Reset mid-frame with a pending AW and 5 buffered beats
      aw_hold = 1'b1;
      run_frame(64'h1FE0, 10, 5, 16'h0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_awvalid", axiAwValid, 1);
      srst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_awvalid", axiAwValid, 0);
      check("mid_rst_wvalid", axiWValid, 0);
      check("mid_rst_setupstop", setupStop, 0);
      srst = 1'b0;
      aw_hold = 1'b0;
      w_first = 1'b1;
      aw_hs = 0;
      wl_hs = 0;
      @(posedge clk); #1;
      expect_burst(64'h2000, 2);
      run_frame(64'h2000, 3, 3, 16'h0, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
